pipeline_chain: RTL
===================

PIPELINE_CHAIN -- requirements
Module: pipeline_chain

Interface
- REQ-001: The block SHALL take parameter WIDTH, default 32, as the payload width in bits (legal range 1..64).
- REQ-002: The block SHALL take parameter STAGES, default 4, as the number of pipeline stages (legal range 1..16).
- REQ-003: The block SHALL use one clock; reset is synchronous and active-low.
- REQ-004: Port clk, input, 1 bit: clock, rising edge.
- REQ-005: Port reset, input, 1 bit: synchronous active-low reset.
- REQ-006: Port in_valid, input, 1 bit: upstream item present.
- REQ-007: Port in_data, input, WIDTH bits: upstream payload.
- REQ-008: Port in_ready, output, 1 bit: stage 0 can accept this cycle.
- REQ-009: Port flush_mask_i, input, STAGES bits: bit i kills stage i's content at this clock edge.
- REQ-010: Port out_valid, output, 1 bit: last stage holds a live item.
- REQ-011: Port out_data, output, WIDTH bits: payload of the last stage.
- REQ-012: Port out_ready, input, 1 bit: downstream accepts.
- REQ-013: Port stage_valid_o, output, STAGES bits: registered valid bit of each stage.
- REQ-014: Port occupancy_o, output, clog2(STAGES+1) bits: count of set stage_valid_o bits.
- REQ-015: Port flushed_cnt_o, output, 16 bits: saturating count of valid items killed by flush.

Function
- REQ-016: Per stage i, the block SHALL hold a valid bit v[i] and a data register d[i]; stage 0 is youngest and stage STAGES-1 is oldest.
- REQ-017: Effective valid SHALL be ev[i] = v[i] AND NOT flush_mask_i[i]; a flushed stage never forwards its item.
- REQ-018: The ready chain SHALL be r[STAGES] = out_ready and r[i] = NOT ev[i] OR r[i+1], evaluated combinationally, with in_ready = r[0].
- REQ-019: Source for stage i SHALL be in_valid/in_data when i=0, else ev[i-1]/d[i-1].
- REQ-020: At each edge, when r[i]=1, v[i] SHALL load the source valid, and d[i] SHALL load the source data only if the source valid is 1; when r[i]=0, v[i] and d[i] SHALL hold.
- REQ-021: When flush_mask_i[i]=1, v[i] SHALL be 0 after the edge regardless of REQ-020, and any item entering stage i that cycle SHALL be discarded, with the upstream handshake still counted as complete.
- REQ-022: out_valid SHALL equal ev[STAGES-1], and out_data SHALL equal d[STAGES-1].
- REQ-023: Transfer out SHALL occur iff out_valid AND out_ready.
- REQ-024: The chain SHALL collapse bubbles: an empty or flushed stage accepts even when downstream is stalled.
- REQ-025: Latency with no stall SHALL be STAGES cycles from accepted input to out_valid.
- REQ-026: Throughput SHALL be 1 item per cycle sustained.
- REQ-027: Items SHALL never be duplicated or reordered.
- REQ-028: flushed_cnt_o SHALL increase each cycle by popcount(v AND flush_mask_i), saturating at 0xFFFF and never wrapping.
- REQ-029: occupancy_o SHALL be derived from the registered v bits only.
- REQ-030: With STAGES=1, the block SHALL behave as a single skid-free register with in_ready = NOT ev[0] OR out_ready.

Reset
- REQ-031: While reset=0 at a rising edge, the block SHALL clear all v[i], all d[i], and flushed_cnt_o to 0, overriding any handshake or flush that cycle.
- REQ-032: In the first cycle after reset: out_valid=0, out_data=0, stage_valid_o=0, occupancy_o=0, flushed_cnt_o=0, and in_ready=1.
- REQ-033: Reset asserted mid-stream SHALL discard all held items without incrementing flushed_cnt_o.

Verification (WIDTH=32, STAGES=4)
- REQ-034: Stream: in_valid=1 with data 1,2,3,... and out_ready=1 -> out_valid rises 4 cycles after the first accept with out_data=1, then 2,3,... one per cycle, and in_ready stays 1.
- REQ-035: Backpressure: out_ready=0 with continuous input -> in_ready=0 after 4 accepts and occupancy_o=4; then out_ready=1 -> outputs 1,2,3,4 in order with no loss.
- REQ-036: Bubble collapse: out_ready=0, items 0xA then 0xB sent 3 cycles apart -> stage_valid_o settles at 4'b1100, d[3]=0xA, d[2]=0xB, occupancy_o=2.
- REQ-037: Flush: chain full with 0xA..0xD (0xA oldest), out_ready=0, flush_mask_i=4'b0011 for one cycle -> stage_valid_o=4'b1100, flushed_cnt_o=2; then out_ready=1 -> only 0xA, 0xB emerge.
- REQ-038: Reset mid-stream: chain full, reset=0 for one edge -> all outputs 0, in_ready=1, flushed_cnt_o=0.
- REQ-039: Saturation: flushed_cnt_o preloaded near its limit via repeated full flushes at 0xFFFE plus a 4-stage flush -> flushed_cnt_o=0xFFFF and it holds there.

Source files
------------

// File: rtl/pipeline_chain.sv
// Elastic multi-stage register chain with bubble collapse, per-stage flush
// and a saturating count of items killed by flush.
module pipeline_chain #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   input  logic [STAGES-1:0]           flush_mask_i,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready,
   output logic [STAGES-1:0]           stage_valid_o,
   output logic [$clog2(STAGES+1)-1:0] occupancy_o,
   output logic [15:0]                 flushed_cnt_o
);

   localparam int unsigned OCC_W  = $clog2(STAGES + 1);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned KILL_W = CNT_W + 1;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [STAGES-1:0] ev;
   logic [STAGES-1:0] src_v;
   logic [STAGES:0]   rdy;
   logic [WIDTH-1:0]  d_q   [STAGES];
   logic [WIDTH-1:0]  d_d   [STAGES];
   logic [WIDTH-1:0]  src_d [STAGES];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [KILL_W-1:0] kill;
   logic [KILL_W-1:0] cnt_sum;
   logic [OCC_W-1:0]  occ;

   // Effective valid and backward ready chain; a flushed stage looks empty.
   always_comb begin
      ev          = v_q & ~flush_mask_i;
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         rdy[i] = ~ev[i] | rdy[i+1];
      end
   end

   // Each stage is fed by the input port or by its upstream neighbour.
   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid;
      for (int i = 0; i < int'(STAGES); i++) begin
         src_d[i] = in_data;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
         src_v[i] = ev[i-1];
         src_d[i] = d_q[i-1];
      end
   end

   // Stage update; flush wins over any load into the same stage.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      for (int i = 0; i < int'(STAGES); i++) begin
         if (rdy[i]) begin
            v_d[i] = src_v[i];
            if (src_v[i]) begin
               d_d[i] = src_d[i];
            end
         end
         if (flush_mask_i[i]) begin
            v_d[i] = 1'b0;
         end
      end
   end

   // Killed-item counter, one extra bit to detect saturation.
   always_comb begin
      kill = '0;
      for (int i = 0; i < int'(STAGES); i++) begin
         kill = kill + KILL_W'(v_q[i] & flush_mask_i[i]);
      end
      cnt_sum = KILL_W'(cnt_q) + kill;
      cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < int'(STAGES); i++) begin
         occ = occ + OCC_W'(v_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         v_q   <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < int'(STAGES); i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign in_ready      = rdy[0];
   assign out_valid     = ev[STAGES-1];
   assign out_data      = d_q[STAGES-1];
   assign stage_valid_o = v_q;
   assign occupancy_o   = occ;
   assign flushed_cnt_o = cnt_q;

endmodule
